// File: rtl/fir_cmplx_decim.sv
// fir_cmplx_decim: decimating complex FIR between an input FIFO and an FWFT output FIFO
// Ports: clock, reset (async, active-low); i_in/q_in/in_wr_en/in_full feed the input FIFO;
//        real_dout/imag_dout/out_rd_en/out_empty expose the head of the output FIFO.
module fir_cmplx_decim #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS = 20,
  parameter int DECIM = 1,
  parameter int FRAC_BITS = 10,
  parameter int FIFO_DEPTH = 16,
  parameter logic [TAPS-1:0][DATA_WIDTH-1:0] H_REAL = (TAPS*DATA_WIDTH)'(1) << FRAC_BITS,
  parameter logic [TAPS-1:0][DATA_WIDTH-1:0] H_IMAG = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic                  in_wr_en,
  output logic                  in_full,
  output logic [DATA_WIDTH-1:0] real_dout,
  output logic [DATA_WIDTH-1:0] imag_dout,
  input  logic                  out_rd_en,
  output logic                  out_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2*DATA_WIDTH;
  localparam int ACCW = PW + $clog2(TAPS);
  localparam int TW = $clog2(TAPS);
  typedef enum logic [1:0] {IDLE, SHIFT, MAC, WRITE} state_t;
  state_t state_q, state_d;
  logic [AW:0] iwp_q, iwp_d, irp_q, irp_d, owp_q, owp_d, orp_q, orp_d;
  logic [2*DATA_WIDTH-1:0] in_mem_q [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] out_mem_q [FIFO_DEPTH];
  logic signed [DATA_WIDTH-1:0] xr_q [TAPS], xr_d [TAPS], xi_q [TAPS], xi_d [TAPS];
  logic signed [ACCW-1:0] re_acc_q, re_acc_d, im_acc_q, im_acc_d, re_term, im_term;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [TW-1:0] tap_q, tap_d;
  logic [4:0] dcnt_q, dcnt_d;
  logic in_empty, out_full, in_push, in_pop, out_push, out_pop;
  assign in_empty = iwp_q == irp_q;
  assign in_full = (iwp_q ^ irp_q) == {1'b1, AW'(0)};
  assign out_empty = owp_q == orp_q;
  assign out_full = (owp_q ^ orp_q) == {1'b1, AW'(0)};
  // SHIFT is only entered with data present, so a pop there is always valid
  assign in_pop = state_q == SHIFT;
  assign in_push = in_wr_en && (!in_full || in_pop);
  assign out_pop = out_rd_en && !out_empty;
  assign out_push = state_q == WRITE && (!out_full || out_pop);
  assign {real_dout, imag_dout} = out_empty ? '0 : out_mem_q[orp_q[AW-1:0]];
  assign p_rr = PW'(xr_q[tap_q]) * PW'($signed(H_REAL[tap_q]));
  assign p_ii = PW'(xi_q[tap_q]) * PW'($signed(H_IMAG[tap_q]));
  assign p_ri = PW'(xr_q[tap_q]) * PW'($signed(H_IMAG[tap_q]));
  assign p_ir = PW'(xi_q[tap_q]) * PW'($signed(H_REAL[tap_q]));
  // each tap term is dequantized on its own before accumulation
  assign re_term = (ACCW'(p_rr) - ACCW'(p_ii)) >>> FRAC_BITS;
  assign im_term = (ACCW'(p_ri) + ACCW'(p_ir)) >>> FRAC_BITS;
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    dcnt_d = dcnt_q;
    re_acc_d = re_acc_q;
    im_acc_d = im_acc_q;
    xr_d = xr_q;
    xi_d = xi_q;
    iwp_d = iwp_q + (AW+1)'(in_push);
    irp_d = irp_q + (AW+1)'(in_pop);
    owp_d = owp_q + (AW+1)'(out_push);
    orp_d = orp_q + (AW+1)'(out_pop);
    case (state_q)
      IDLE: state_d = in_empty ? IDLE : SHIFT;
      SHIFT: begin
        for (int k = TAPS-1; k > 0; k--) begin
          xr_d[k] = xr_q[k-1];
          xi_d[k] = xi_q[k-1];
        end
        {xr_d[0], xi_d[0]} = in_mem_q[irp_q[AW-1:0]];
        dcnt_d = (dcnt_q == 5'(DECIM-1)) ? '0 : dcnt_q + 5'd1;
        state_d = (dcnt_d == '0) ? MAC : IDLE;
        tap_d = '0;
      end
      MAC: begin
        re_acc_d = re_acc_q + re_term;
        im_acc_d = im_acc_q + im_term;
        tap_d = tap_q + TW'(1);
        state_d = (tap_q == TW'(TAPS-1)) ? WRITE : MAC;
      end
      WRITE: begin
        re_acc_d = out_push ? '0 : re_acc_q;
        im_acc_d = out_push ? '0 : im_acc_q;
        state_d = out_push ? IDLE : WRITE;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tap_q <= '0;
      dcnt_q <= '0;
      re_acc_q <= '0;
      im_acc_q <= '0;
      xr_q <= '{default: '0};
      xi_q <= '{default: '0};
      iwp_q <= '0;
      irp_q <= '0;
      owp_q <= '0;
      orp_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      dcnt_q <= dcnt_d;
      re_acc_q <= re_acc_d;
      im_acc_q <= im_acc_d;
      xr_q <= xr_d;
      xi_q <= xi_d;
      iwp_q <= iwp_d;
      irp_q <= irp_d;
      owp_q <= owp_d;
      orp_q <= orp_d;
    end
  end
  always_ff @(posedge clock) begin
    if (in_push) in_mem_q[iwp_q[AW-1:0]] <= {i_in, q_in};
    if (out_push) out_mem_q[owp_q[AW-1:0]] <= {re_acc_q[DATA_WIDTH-1:0], im_acc_q[DATA_WIDTH-1:0]};
  end
endmodule

// File: tb/tb_fir_cmplx_decim.sv
// tb_fir_cmplx_decim: directed checks of four fir_cmplx_decim configurations against a sample-history model
module tb_fir_cmplx_decim;
  logic clock = 0, reset = 0;
  logic [3:0] wr = '0, rd = '0;
  wire [3:0] full, empty;
  logic [31:0] ii [4], qi [4];
  wire [31:0] rdo [4], ido [4];
  int checks = 0, errors = 0;
  longint hr_m [4][20], hi_m [4][20];
  int taps_m [4] = '{20, 4, 4, 4};
  int dec_m [4] = '{1, 1, 1, 4};
  longint xs_r [4][$], xs_i [4][$];
  logic [63:0] expq [4][$], got [4][$];
  always #5 clock = ~clock;
  fir_cmplx_decim u0 (.clock(clock), .reset(reset), .i_in(ii[0]), .q_in(qi[0]), .in_wr_en(wr[0]), .in_full(full[0]),
    .real_dout(rdo[0]), .imag_dout(ido[0]), .out_rd_en(rd[0]), .out_empty(empty[0]));
  fir_cmplx_decim #(.TAPS(4), .H_REAL({4{32'd1024}}), .H_IMAG('0)) u1 (.clock(clock), .reset(reset), .i_in(ii[1]),
    .q_in(qi[1]), .in_wr_en(wr[1]), .in_full(full[1]), .real_dout(rdo[1]), .imag_dout(ido[1]), .out_rd_en(rd[1]),
    .out_empty(empty[1]));
  fir_cmplx_decim #(.TAPS(4), .H_REAL('0), .H_IMAG(128'd1024)) u2 (.clock(clock), .reset(reset), .i_in(ii[2]),
    .q_in(qi[2]), .in_wr_en(wr[2]), .in_full(full[2]), .real_dout(rdo[2]), .imag_dout(ido[2]), .out_rd_en(rd[2]),
    .out_empty(empty[2]));
  fir_cmplx_decim #(.TAPS(4), .DECIM(4), .H_REAL({32'd512, 32'hFFFFFC00, 32'd2048, 32'd1024}),
    .H_IMAG({32'd0, 32'd256, 32'hFFFFFE00, 32'd0})) u3 (.clock(clock), .reset(reset), .i_in(ii[3]), .q_in(qi[3]),
    .in_wr_en(wr[3]), .in_full(full[3]), .real_dout(rdo[3]), .imag_dout(ido[3]), .out_rd_en(rd[3]),
    .out_empty(empty[3]));
  // output n is the filter applied to the history right after accepted sample dec*(n+1)-1
  function automatic void mpush(int k, logic [31:0] r, logic [31:0] i);
    longint sr = 0, si = 0;
    int m;
    xs_r[k].push_back(longint'($signed(r)));
    xs_i[k].push_back(longint'($signed(i)));
    m = xs_r[k].size() - 1;
    if (xs_r[k].size() % dec_m[k] != 0) return;
    for (int t = 0; t < taps_m[k] && t <= m; t++) begin
      sr += (xs_r[k][m-t] * hr_m[k][t] - xs_i[k][m-t] * hi_m[k][t]) >>> 10;
      si += (xs_r[k][m-t] * hi_m[k][t] + xs_i[k][m-t] * hr_m[k][t]) >>> 10;
    end
    expq[k].push_back({sr[31:0], si[31:0]});
  endfunction
  always @(negedge reset)
    for (int k = 0; k < 4; k++) begin
      xs_r[k].delete();
      xs_i[k].delete();
      expq[k].delete();
    end
  always @(posedge clock)
    if (reset)
      for (int k = 0; k < 4; k++) begin
        if (rd[k] && !empty[k]) begin
          got[k].push_back({rdo[k], ido[k]});
          if (expq[k].size() > 0) void'(expq[k].pop_front());
        end
        if (wr[k] && !full[k]) mpush(k, ii[k], qi[k]);
      end
  always @(negedge clock)
    if (reset)
      for (int k = 0; k < 4; k++)
        if (!empty[k]) begin
          checks++;
          if (expq[k].size() == 0) begin
            errors++;
            $display("FAIL head%0d got %h_%h expected no output", k, rdo[k], ido[k]);
          end else if ({rdo[k], ido[k]} !== expq[k][0]) begin
            errors++;
            $display("FAIL head%0d got %h_%h expected %h", k, rdo[k], ido[k], expq[k][0]);
          end
        end
  task automatic chk(string n, logic [63:0] g, logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, g, e);
    end
  endtask
  task automatic push(int k, logic [31:0] r, logic [31:0] i);
    ii[k] = r;
    qi[k] = i;
    wr[k] = 1'b1;
    @(negedge clock);
    wr[k] = 1'b0;
  endtask
  task automatic drain(int k, int n);
    int c, start;
    c = 0;
    start = got[k].size();
    rd[k] = 1'b1;
    while (got[k].size() < start + n && c < 2000) begin
      @(negedge clock);
      c++;
    end
    rd[k] = 1'b0;
    chk($sformatf("drain%0d_count", k), 64'(got[k].size() - start), 64'(n));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int c, nacc, fc;
    for (int k = 0; k < 4; k++) begin
      ii[k] = '0;
      qi[k] = '0;
      for (int t = 0; t < 20; t++) begin
        hr_m[k][t] = 0;
        hi_m[k][t] = 0;
      end
    end
    hr_m[0][0] = 1024;
    for (int t = 0; t < 4; t++) hr_m[1][t] = 1024;
    hi_m[2][0] = 1024;
    hr_m[3][0] = 1024; hr_m[3][1] = 2048; hr_m[3][2] = -1024; hr_m[3][3] = 512;
    hi_m[3][1] = -512; hi_m[3][2] = 256;
    repeat (3) @(negedge clock);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_empty", 64'(empty), 64'hF);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_dout%0d", k), {rdo[k], ido[k]}, 64'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("rel_full", 64'(full), 64'h0);
    chk("rel_empty", 64'(empty), 64'hF);
    chk("rel_dout0", {rdo[0], ido[0]}, 64'h0);
    push(0, 32'h00000400, 32'hFFFFFC00);
    push(0, 32'd5, 32'd7);
    c = 1;
    while (empty[0] && c < 60) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (c > 25) begin
      errors++;
      $display("FAIL latency got %0d cycles required at most 25", c);
    end
    drain(0, 2);
    chk("id0", got[0][0], 64'h00000400_FFFFFC00);
    chk("id1", got[0][1], 64'h00000005_00000007);
    push(1, 32'd1024, 32'd0);
    repeat (5) push(1, 32'd0, 32'd0);
    drain(1, 6);
    for (int n = 0; n < 4; n++) chk($sformatf("sum4_%0d", n), got[1][n], 64'h00000400_00000000);
    chk("sum4_4", got[1][4], 64'h0);
    chk("sum4_5", got[1][5], 64'h0);
    push(2, 32'd3, 32'd5);
    push(2, 32'hFFFFFFF9, 32'd2);
    drain(2, 2);
    chk("jmul0", got[2][0], 64'hFFFFFFFB_00000003);
    chk("jmul1", got[2][1], 64'hFFFFFFFE_FFFFFFF9);
    for (int j = 0; j < 16; j++) push(3, 32'((j + 1) * 100), 32'(j * 37 - 200));
    drain(3, 4);
    chk("dec0", got[3][0], 64'h0000033B_FFFFFE86);
    repeat (20) @(negedge clock);
    chk("dec_count", 64'(empty[3]), 64'h1);
    nacc = 0;
    fc = 0;
    for (int k = 0; k < 1500 && fc < 50; k++) begin
      wr[0] = !full[0];
      ii[0] = 32'(nacc * 3 - 40);
      qi[0] = 32'(1000 - nacc * 11);
      if (!full[0]) nacc++;
      fc = full[0] ? fc + 1 : 0;
      @(negedge clock);
    end
    wr[0] = 1'b0;
    chk("bp_fill", 64'(fc), 64'd50);
    repeat (5) begin
      ii[0] = 32'hDEADBEEF;
      qi[0] = 32'hDEADBEEF;
      wr[0] = 1'b1;
      @(negedge clock);
    end
    wr[0] = 1'b0;
    chk("bp_full_hold", 64'(full[0]), 64'h1);
    drain(0, nacc);
    repeat (30) @(negedge clock);
    chk("bp_drained", 64'(empty[0]), 64'h1);
    push(1, 32'd1024, 32'd0);
    push(1, 32'd1024, 32'd0);
    push(0, 32'd9, 32'd9);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_full", 64'(full), 64'h0);
    chk("mid_empty", 64'(empty), 64'hF);
    reset = 1'b1;
    push(1, 32'd100, 32'd50);
    drain(1, 1);
    chk("restart", got[1][$], 64'h00000064_00000032);
    repeat (40) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("end_empty%0d", k), 64'(empty[k]), 64'h1);
      chk($sformatf("end_model%0d", k), 64'(expq[k].size()), 64'h0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_cmplx_decim.md
FIR_CMPLX_DECIM -- requirements
Module: fir_cmplx_decim

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32: width of each I/Q input and real/imag output word, two's complement.
REQ-002 SHALL have parameter TAPS, 20: filter length, 2..64.
REQ-003 SHALL have parameter DECIM, 1: decimation factor, 1..16.
REQ-004 SHALL have parameter FRAC_BITS, 10: coefficient fractional bits, the dequantize shift.
REQ-005 SHALL have parameter FIFO_DEPTH, 16: depth of the input FIFO and of the output FIFO, power of two >= 4.
REQ-006 SHALL have parameters H_REAL and H_IMAG, TAPS x DATA_WIDTH signed arrays; the default is identity: H_REAL[0]=1<<FRAC_BITS, all other entries 0.
REQ-007 SHALL have port clock, in, 1: sole clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, in, 1: asynchronous, active-low reset.
REQ-009 SHALL have ports i_in and q_in, in, DATA_WIDTH each: input sample real and imaginary parts.
REQ-010 SHALL have port in_wr_en, in, 1: pushes {i_in,q_in} into the input FIFO.
REQ-011 SHALL have port in_full, out, 1: input FIFO is full.
REQ-012 SHALL have ports real_dout and imag_dout, out, DATA_WIDTH each: head of the output FIFO, first-word-fall-through.
REQ-013 SHALL have port out_rd_en, in, 1: pops the output FIFO.
REQ-014 SHALL have port out_empty, out, 1: output FIFO is empty.

Function
REQ-015 SHALL ignore in_wr_en when in_full=1, and ignore out_rd_en when out_empty=1; no overflow or underflow corrupts state.
REQ-016 SHALL accept a simultaneous push and pop on the same FIFO in one cycle, including when it is full or empty, with its occupancy unchanged.
REQ-017 SHALL keep a TAPS-deep complex history register, zero after reset; each accepted sample shifts in at index 0.
REQ-018 SHALL run the FSM IDLE -> SHIFT -> (MAC or IDLE) -> WRITE -> IDLE.
REQ-019 SHALL move from IDLE to SHIFT only when the input FIFO is non-empty.
REQ-020 SHALL, in SHIFT, pop one sample into history and advance decim_cnt modulo DECIM.
REQ-021 SHALL go from SHIFT to MAC when the post-pop decim_cnt is 0, else back to IDLE; with DECIM=1, every input produces one output.
REQ-022 SHALL, in MAC, process one tap per cycle for TAPS cycles: re_acc += (xr*hr - xi*hi) >>> FRAC_BITS; im_acc += (xr*hi + xi*hr) >>> FRAC_BITS.
REQ-023 SHALL compute products at 2*DATA_WIDTH and accumulate at 2*DATA_WIDTH+log2(TAPS), with arithmetic shifts.
REQ-024 SHALL, in WRITE, wait while the output FIFO is full, then push the low DATA_WIDTH bits of each accumulator (truncate, no saturation) and clear both accumulators.
REQ-025 SHALL produce the first output on real_dout/imag_dout, with out_empty=0, no more than TAPS+6 cycles after the first in_wr_en with DECIM=1 and no backpressure.
REQ-026 SHALL sustain one output per TAPS+3 cycles when neither FIFO stalls.
REQ-027 SHALL keep the output stream bit-exact across any out_rd_en stall pattern; backpressure never drops or duplicates samples.
REQ-028 SHALL make its output sample n use history after input sample DECIM*(n+1)-1 (0-based).

Reset
REQ-029 SHALL, on reset=0 at any time including mid-MAC, asynchronously clear the FSM to IDLE and zero decim_cnt, the history, the accumulators and both FIFO pointers.
REQ-030 SHALL drive in_full=0, out_empty=1, real_dout=0 and imag_dout=0 while reset is low and after its release.
REQ-031 SHALL accept in_wr_en on the first rising clock edge after reset returns high.

Verification
REQ-032 SHALL pass: identity coefficients, inputs (0x00000400,0xFFFFFC00),(5,7) -> outputs equal the inputs exactly, in order.
REQ-033 SHALL pass: TAPS=4, H_REAL all 1024, H_IMAG 0, impulse I=1024,Q=0 then zeros -> real_dout 1024 four times then 0; imag_dout always 0.
REQ-034 SHALL pass: H_IMAG[0]=1024 with the other taps 0, input (3,5) -> real=-5 (0xFFFFFFFB), imag=3.
REQ-035 SHALL pass: DECIM=4, 16 inputs -> exactly 4 outputs, matching golden taps at inputs 3,7,11,15.
REQ-036 SHALL pass: out_rd_en held low until out_empty=0 persists and in_full=1 -> no input is lost; a full drain then matches the golden model and the error count is 0.
REQ-037 SHALL pass: reset asserted for 1 cycle mid-MAC -> out_empty=1 and in_full=0; a restarted stream matches golden output from zero history.
